// File: rtl/port_serializer.sv
// rtl/port_serializer.sv - output-port serializer: pops payload words and shifts them out LSB-first with framing
module port_serializer #(
    parameter int WIDTH = 32,
    parameter int GAP   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] fifo_data,
    input  logic             fifo_empty,
    input  logic             hold,
    output logic             fifo_pop,
    output logic             dout,
    output logic             valido_n,
    output logic             frameo_n,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

    // S_TAIL is the cycle after the last bit, where the line returns to idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_SHIFT,
        S_TAIL,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             pop_q, pop_d;
    logic             dout_q, dout_d;
    logic             vn_q, vn_d;
    logic             fn_q, fn_d;
    logic             busy_q, busy_d;

    // Next-state and registered-output logic; the bit index only advances on non-held edges
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;
        pop_d   = 1'b0;
        dout_d  = 1'b0;
        vn_d    = 1'b1;
        fn_d    = fn_q;
        case (state_q)
            S_IDLE: begin
                fn_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = S_POP;
                    pop_d   = 1'b1;
                end
            end
            S_POP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                // The word is only valid now, so bit 0 comes straight from fifo_data
                state_d = S_SHIFT;
                fn_d    = 1'b0;
                shreg_d = fifo_data;
                cnt_d   = '0;
                if (!hold) begin
                    dout_d  = fifo_data[0];
                    vn_d    = 1'b0;
                    shreg_d = fifo_data >> 1;
                    cnt_d   = CW'(1);
                end
            end
            S_SHIFT: begin
                if (!hold) begin
                    dout_d  = shreg_q[0];
                    vn_d    = 1'b0;
                    shreg_d = shreg_q >> 1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        fn_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_TAIL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_TAIL: begin
                fn_d  = 1'b1;
                gap_d = GW'(GAP);
                if (GAP == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            pop_q   <= 1'b0;
            dout_q  <= 1'b0;
            vn_q    <= 1'b1;
            fn_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            pop_q   <= pop_d;
            dout_q  <= dout_d;
            vn_q    <= vn_d;
            fn_q    <= fn_d;
            busy_q  <= busy_d;
        end
    end

    assign fifo_pop = pop_q;
    assign dout     = dout_q;
    assign valido_n = vn_q;
    assign frameo_n = fn_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_port_serializer.sv
// tb/tb_port_serializer.sv - self-checking bench for port_serializer with a FIFO model and frame scoreboard
module tb_port_serializer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [2:0]  rst_s  = 3'b111;
    logic [2:0]  emp_s  = 3'b111;
    logic [2:0]  hold_s = 3'b000;
    logic [31:0] fd [3];
    wire  [2:0]  pop_s, dout_s, vn_s, fn_s, busy_s;

    int checks   = 0;
    int failures = 0;

    // FIFO contents and scoreboard state for the instance under test
    logic [31:0] fq[$];
    logic [31:0] words[$];
    int          pops[$];
    int          flens[$];
    int          cyc, nbits, fstart, hleft, bad_frame, bad_dout, pop_empty;
    bit          infr, pend, rand_hold;
    logic [31:0] acc, pend_word;
    int          hb[2], hl[2];
    bit          hdone[2];

    port_serializer #(.WIDTH(32), .GAP(1)) u_w32_g1 (
        .clock(clock), .reset(rst_s[0]), .fifo_data(fd[0]), .fifo_empty(emp_s[0]), .hold(hold_s[0]),
        .fifo_pop(pop_s[0]), .dout(dout_s[0]), .valido_n(vn_s[0]), .frameo_n(fn_s[0]), .busy(busy_s[0]));
    port_serializer #(.WIDTH(32), .GAP(2)) u_w32_g2 (
        .clock(clock), .reset(rst_s[1]), .fifo_data(fd[1]), .fifo_empty(emp_s[1]), .hold(hold_s[1]),
        .fifo_pop(pop_s[1]), .dout(dout_s[1]), .valido_n(vn_s[1]), .frameo_n(fn_s[1]), .busy(busy_s[1]));
    port_serializer #(.WIDTH(8), .GAP(0)) u_w8_g0 (
        .clock(clock), .reset(rst_s[2]), .fifo_data(fd[2][7:0]), .fifo_empty(emp_s[2]), .hold(hold_s[2]),
        .fifo_pop(pop_s[2]), .dout(dout_s[2]), .valido_n(vn_s[2]), .frameo_n(fn_s[2]), .busy(busy_s[2]));

    function automatic logic [31:0] word_at(input int i);
        return (i < words.size()) ? words[i] : 32'hxxxxxxxx;
    endfunction

    function automatic int pop_at(input int i);
        return (i < pops.size()) ? pops[i] : -1;
    endfunction

    function automatic int flen_at(input int i);
        return (i < flens.size()) ? flens[i] : -1;
    endfunction

    task automatic clear_obs();
        words.delete();
        pops.delete();
        flens.delete();
        cyc = 0; nbits = 0; fstart = 0; hleft = 0;
        bad_frame = 0; bad_dout = 0; pop_empty = 0;
        infr = 0; pend = 0; rand_hold = 0; acc = '0;
        hb = '{-1, -1}; hl = '{0, 0}; hdone = '{0, 0};
    endtask

    // One cycle of FIFO model, serial-line scoreboard and hold generation, run at the falling edge
    task automatic observe(input int k, input int w);
        cyc++;
        if (pend) begin
            fd[k] = pend_word;
            pend  = 0;
        end else begin
            fd[k] = $urandom();
        end
        if (pop_s[k] === 1'b1) begin
            pops.push_back(cyc);
            if (fq.size() == 0) begin
                pop_empty++;
            end else begin
                pend_word = fq.pop_front();
                pend      = 1;
            end
        end
        if (!infr && fn_s[k] === 1'b0) begin
            infr = 1; fstart = cyc; nbits = 0; acc = '0;
        end
        if (vn_s[k] === 1'b0) begin
            if (!infr || nbits >= w) begin
                bad_frame++;
            end else begin
                acc[nbits] = dout_s[k];
                if (nbits == w - 1) begin
                    if (fn_s[k] !== 1'b1) bad_frame++;
                    words.push_back(acc);
                    flens.push_back(cyc - fstart + 1);
                    infr = 0;
                end else if (fn_s[k] !== 1'b0) begin
                    bad_frame++;
                end
                nbits++;
            end
        end else begin
            if (dout_s[k] !== 1'b0) bad_dout++;
            if (infr && fn_s[k] !== 1'b0) bad_frame++;
        end
        if (rand_hold) begin
            hold_s[k] = ($urandom_range(0, 3) == 0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!hdone[i] && infr && nbits == hb[i]) begin
                    hdone[i] = 1;
                    hleft    = hl[i];
                end
            end
            hold_s[k] = (hleft > 0);
            if (hleft > 0) hleft--;
        end
        emp_s[k] = (fq.size() == 0);
    endtask

    task automatic run(input int k, input int w, input int n, input int maxc);
        int c = 0;
        emp_s[k] = (fq.size() == 0);
        while (words.size() < n && c < maxc) begin
            @(negedge clock);
            observe(k, w);
            c++;
        end
        repeat (w + 6) begin
            @(negedge clock);
            observe(k, w);
        end
        hold_s[k] = 1'b0;
    endtask

    task automatic check_clean(input string name);
        checks++;
        if (bad_frame !== 0 || bad_dout !== 0 || pop_empty !== 0) begin
            failures++;
            $display("FAIL %s_line: frame_err=%0d dout_err=%0d empty_pops=%0d required all 0",
                     name, bad_frame, bad_dout, pop_empty);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({pop_s[k], dout_s[k], vn_s[k], fn_s[k], busy_s[k]} !== 5'b00110) begin
                failures++;
                $display("FAIL reset_values[%0d]: pop,dout,vn,fn,busy=%b required 00110", k,
                         {pop_s[k], dout_s[k], vn_s[k], fn_s[k], busy_s[k]});
            end
        end
    endtask

    task automatic test_idle_empty();
        int viol = 0;
        rst_s = 3'b000;
        emp_s = 3'b111;
        repeat (100) begin
            @(negedge clock);
            if (pop_s !== 3'b000 || busy_s !== 3'b000 || vn_s !== 3'b111 || fn_s !== 3'b111) viol++;
        end
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL idle_empty: %0d cycles with activity, required 0", viol);
        end
    endtask

    task automatic test_single_word();
        clear_obs();
        fq.push_back(32'hA5A50F0F);
        run(0, 32, 1, 100);
        checks++;
        if (pops.size() !== 1) begin
            failures++;
            $display("FAIL single_pops: got %0d pops required 1", pops.size());
        end
        checks++;
        if (word_at(0) !== 32'hA5A50F0F) begin
            failures++;
            $display("FAIL single_word: got %h required a5a50f0f", word_at(0));
        end
        checks++;
        if (flen_at(0) !== 32) begin
            failures++;
            $display("FAIL single_frame_len: got %0d required 32", flen_at(0));
        end
        checks++;
        if (busy_s[0] !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_after: got %b required 0", busy_s[0]);
        end
        check_clean("single");
    endtask

    task automatic test_back_to_back();
        clear_obs();
        fq.push_back(32'h00000001);
        fq.push_back(32'h80000000);
        run(1, 32, 2, 200);
        checks++;
        if (pops.size() !== 2 || pop_at(1) - pop_at(0) !== 32 + 2 + 3) begin
            failures++;
            $display("FAIL b2b_pop_spacing: got %0d pops spaced %0d required 2 spaced %0d",
                     pops.size(), pop_at(1) - pop_at(0), 32 + 2 + 3);
        end
        checks++;
        if (word_at(0) !== 32'h00000001 || word_at(1) !== 32'h80000000) begin
            failures++;
            $display("FAIL b2b_words: got %h %h required 00000001 80000000", word_at(0), word_at(1));
        end
        check_clean("b2b");
    endtask

    task automatic test_hold();
        logic [31:0] w = $urandom();
        clear_obs();
        fq.push_back(w);
        hb = '{10, 31};
        hl = '{3, 1};
        run(0, 32, 1, 150);
        checks++;
        if (word_at(0) !== w) begin
            failures++;
            $display("FAIL hold_word: got %h required %h", word_at(0), w);
        end
        checks++;
        if (flen_at(0) !== 32 + 4) begin
            failures++;
            $display("FAIL hold_frame_len: got %0d required %0d", flen_at(0), 36);
        end
        check_clean("hold");
    endtask

    task automatic test_reset_mid();
        logic [31:0] w1 = $urandom();
        logic [31:0] w2 = $urandom();
        int c = 0;
        clear_obs();
        fq.push_back(w1);
        fq.push_back(w2);
        emp_s[0] = 1'b0;
        while (!(infr && nbits == 15) && c < 100) begin
            @(negedge clock);
            observe(0, 32);
            c++;
        end
        checks++;
        if (c >= 100) begin
            failures++;
            $display("FAIL reset_mid_reach_bit15: timed out after %0d cycles", c);
        end
        rst_s[0]  = 1'b1;
        hold_s[0] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clock);
            checks++;
            if ({pop_s[0], dout_s[0], vn_s[0], fn_s[0], busy_s[0]} !== 5'b00110) begin
                failures++;
                $display("FAIL reset_mid_outputs[%0d]: pop,dout,vn,fn,busy=%b required 00110", r,
                         {pop_s[0], dout_s[0], vn_s[0], fn_s[0], busy_s[0]});
            end
        end
        rst_s[0] = 1'b0;
        clear_obs();
        run(0, 32, 1, 100);
        checks++;
        if (pops.size() !== 1 || word_at(0) !== w2) begin
            failures++;
            $display("FAIL reset_mid_next_word: got %0d pops word %h required 1 pop word %h",
                     pops.size(), word_at(0), w2);
        end
        check_clean("reset_mid");
    endtask

    task automatic test_w8_gap0();
        clear_obs();
        fq.push_back(32'h000000FF);
        fq.push_back(32'h00000000);
        run(2, 8, 2, 60);
        checks++;
        if (pops.size() !== 2 || pop_at(1) - pop_at(0) !== 8 + 0 + 3) begin
            failures++;
            $display("FAIL w8_pop_spacing: got %0d pops spaced %0d required 2 spaced 11",
                     pops.size(), pop_at(1) - pop_at(0));
        end
        checks++;
        if (word_at(0) !== 32'h000000FF || word_at(1) !== 32'h00000000) begin
            failures++;
            $display("FAIL w8_words: got %h %h required 000000ff 00000000", word_at(0), word_at(1));
        end
        checks++;
        if (flen_at(0) !== 8 || flen_at(1) !== 8) begin
            failures++;
            $display("FAIL w8_frame_len: got %0d %0d required 8 8", flen_at(0), flen_at(1));
        end
        check_clean("w8");
    endtask

    task automatic test_random(input int k, input int w);
        logic [31:0] exp[$];
        logic [31:0] mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
        int errs = 0;
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            exp.push_back($urandom() & mask);
            fq.push_back(exp[i]);
        end
        rand_hold = 1;
        run(k, w, 5, 5 * (3 * w + 20));
        checks++;
        if (words.size() !== 5 || pops.size() !== 5) begin
            failures++;
            $display("FAIL random_count[%0d]: got %0d words %0d pops required 5 and 5", k, words.size(), pops.size());
        end
        for (int i = 0; i < 5; i++) if (word_at(i) !== exp[i]) errs++;
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL random_words[%0d]: %0d words differ, first got %h required %h", k, errs, word_at(0), exp[0]);
        end
        check_clean("random");
    endtask

    initial begin
        for (int k = 0; k < 3; k++) fd[k] = '0;
        repeat (3) @(negedge clock);
        test_reset();
        test_idle_empty();
        test_single_word();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_w8_gap0();
        test_random(0, 32);
        test_random(2, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
